// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request, bit shift on device clock, ACK check.
// Optional build macro PS2_TX_RETRY_EN: automatic retry (up to 2) of the same byte on NAK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The REQ cycle also holds the clock low, so INHIBIT itself lasts one cycle less.
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_REL,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       clk_sync;
  logic [2:0]       data_sync;
  logic             clk_prev;
  logic             clk_s;
  logic             data_s;
  logic             fall_edge;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic             data_bit;
  logic [CNT_W-1:0] cnt;
  logic             ack_q;
  logic             err_q;
  logic             accept;
  logic             timeout;
  logic             abort;
  logic             last_edge;
  logic             can_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[2];
  assign data_s = data_sync[2];

  // Device edges only matter once we have handed the clock over to the device.
  assign fall_edge = clk_prev & ~clk_s & ((state == SHIFT) | (state == WAIT_REL));
  assign last_edge = fall_edge & (state == SHIFT) & (bit_cnt == 4'd10);
  assign timeout   = ((state == SHIFT) | (state == WAIT_REL)) & (cnt == TO_LAST) & ~fall_edge;
  assign accept    = tx_valid & tx_ready;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= 2'd0;
    end else if (accept) begin
      retry_cnt <= 2'd0;
    end else if (state_nx == INHIBIT && state != IDLE && state != INHIBIT) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end

  assign can_retry = (retry_cnt != 2'd2);
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE:     if (tx_valid) state_nx = INHIBIT;
      INHIBIT:  if (cnt == INH_LAST) state_nx = REQ;
      REQ:      state_nx = SHIFT;
      SHIFT: begin
        if (last_edge) begin
          state_nx = WAIT_REL;
        end else if (timeout) begin
          abort    = 1'b1;
          state_nx = can_retry ? INHIBIT : IDLE;
        end
      end
      WAIT_REL: begin
        if (clk_s && data_s) begin
          state_nx = (!ack_q && can_retry) ? INHIBIT : DONE;
        end else if (timeout) begin
          abort    = 1'b1;
          state_nx = can_retry ? INHIBIT : IDLE;
        end
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Shared counter: inhibit length, then cycles since the last device clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nx == INHIBIT && state != INHIBIT) begin
      cnt <= '0;
    end else if (state == INHIBIT) begin
      cnt <= cnt + 1'b1;
    end else if (state == REQ || fall_edge) begin
      cnt <= '0;
    end else if (state == SHIFT || state == WAIT_REL) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= 8'h00;
      parity_q <= 1'b0;
      bit_cnt  <= 4'd0;
      data_bit <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= abort & ~can_retry;
      if (accept) begin
        byte_q   <= tx_data;
        parity_q <= ~^tx_data;
        ack_q    <= 1'b0;
      end
      if (state == REQ) begin
        bit_cnt  <= 4'd0;
        data_bit <= 1'b1;
      end else if (state == SHIFT && fall_edge) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd8) begin
          data_bit <= ~byte_q[bit_cnt[2:0]];
        end else if (bit_cnt == 4'd8) begin
          data_bit <= ~parity_q;
        end else begin
          data_bit <= 1'b0;
        end
        if (bit_cnt == 4'd10) begin
          ack_q <= ~data_s;
        end
      end
    end
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign ps2_clk_oe  = (state == INHIBIT) | (state == REQ);
  assign ps2_data_oe = (state == REQ) | ((state == SHIFT) & data_bit);
  assign ack_ok      = ack_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;
  logic       dev_clk;
  logic       dev_data;

  int tests;
  int failures;
  int cyc;
  int done_cnt;
  int err_cnt;
  int err_cyc;
  int inhibit_cnt;
  int oe_run;
  int last_oe_run;
  int last_fall_cyc;
  logic ack_at_done;
  logic clk_oe_prev;

  ps2_host_tx #(
    .INHIBIT_CYCLES(100),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk_pin),
    .ps2_data   (ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err        (err)
  );

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt    <= done_cnt + 1;
      ack_at_done <= ack_ok;
    end
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2_clk_oe) begin
      oe_run <= oe_run + 1;
    end else if (oe_run != 0) begin
      last_oe_run <= oe_run;
      oe_run      <= 0;
    end
    if (ps2_clk_oe && !clk_oe_prev) inhibit_cnt <= inhibit_cnt + 1;
    clk_oe_prev <= ps2_clk_oe;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: waits for the request, then clocks `edges` falling edges, sampling
  // the line just before each one; optionally pulls data low for the ACK.
  task automatic device_frame(input int edges, input bit give_ack,
                              output logic [10:0] frame, output bit ok);
    int t;
    ok    = 1'b1;
    frame = '1;
    t     = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= edges; k++) begin
      frame[k-1] = ps2_data_pin;
      if (k == 11 && give_ack) begin
        dev_data = 1'b0;
        repeat (5) @(negedge clk);
      end
      dev_clk       = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int d0);
    int t;
    t = 0;
    while ((done_cnt == d0 || !tx_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    tests++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got ready=%b busy=%b clk_oe=%b data_oe=%b exp 1 0 0 0",
               tx_ready, busy, ps2_clk_oe, ps2_data_oe);
    end
    tests++;
    if (done !== 1'b0 || ack_ok !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_status got done=%b ack=%b err=%b exp 0 0 0", done, ack_ok, err);
    end
  endtask

  task automatic test_send_ed();
    logic [10:0] fr;
    bit ok;
    int d0;
    d0 = done_cnt;
    send_byte(8'hED);
    device_frame(11, 1'b1, fr, ok);
    wait_idle(d0);
    tests++;
    if (!ok || fr !== 11'b1_1_11101101_0) begin
      failures++;
      $display("[TB] FAIL ed_frame got=%b ok=%0d exp=%b", fr, ok, 11'b1_1_11101101_0);
    end
    tests++;
    if (done_cnt !== d0 + 1 || ack_at_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ed_done got done=%0d ack=%b exp done=%0d ack=1", done_cnt - d0, ack_at_done, 1);
    end
  endtask

  task automatic test_send_f4_inhibit();
    logic [10:0] fr;
    bit ok;
    int d0;
    d0 = done_cnt;
    send_byte(8'hF4);
    device_frame(11, 1'b1, fr, ok);
    wait_idle(d0);
    tests++;
    if (!ok || fr !== 11'b1_0_11110100_0) begin
      failures++;
      $display("[TB] FAIL f4_frame got=%b ok=%0d exp=%b", fr, ok, 11'b1_0_11110100_0);
    end
    tests++;
    if (last_oe_run !== 100) begin
      failures++;
      $display("[TB] FAIL f4_inhibit_len got=%0d exp=100", last_oe_run);
    end
    tests++;
    if (done_cnt !== d0 + 1 || ack_at_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL f4_done got done=%0d ack=%b exp 1 1", done_cnt - d0, ack_at_done);
    end
  endtask

  task automatic test_nak();
    logic [10:0] fr;
    bit ok;
    int d0;
    int e0;
    int i0;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inhibit_cnt;
    send_byte(8'hAA);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(11, 1'b0, fr, ok);
      tests++;
      if (!ok || fr !== 11'b1_1_10101010_0) begin
        failures++;
        $display("[TB] FAIL nak_frame attempt=%0d got=%b exp=%b", a, fr, 11'b1_1_10101010_0);
      end
    end
    wait_idle(d0);
    tests++;
    if (done_cnt !== d0 + 1 || ack_at_done !== 1'b0 || err_cnt !== e0) begin
      failures++;
      $display("[TB] FAIL nak_result got done=%0d ack=%b err=%0d exp 1 0 0",
               done_cnt - d0, ack_at_done, err_cnt - e0);
    end
    tests++;
    if (inhibit_cnt !== i0 + ATTEMPTS) begin
      failures++;
      $display("[TB] FAIL nak_attempts got=%0d exp=%0d", inhibit_cnt - i0, ATTEMPTS);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] fr;
    bit ok;
    int d0;
    int e0;
    int t;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF4);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(4, 1'b0, fr, ok);
    end
    t = 0;
    while (err_cnt == e0 && t < 1500) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (err_cnt !== e0 + 1) begin
      failures++;
      $display("[TB] FAIL timeout_err got=%0d exp=1", err_cnt - e0);
    end
    tests++;
    if (err_cyc - last_fall_cyc !== 504) begin
      failures++;
      $display("[TB] FAIL timeout_delay got=%0d exp=504", err_cyc - last_fall_cyc);
    end
    tests++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || done_cnt !== d0) begin
      failures++;
      $display("[TB] FAIL timeout_state got clk_oe=%b data_oe=%b ready=%b done=%0d exp 0 0 1 0",
               ps2_clk_oe, ps2_data_oe, tx_ready, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] fr;
    bit ok;
    int d0;
    send_byte(8'hFF);
    device_frame(0, 1'b0, fr, ok);
    tests++;
    if (!ok || busy !== 1'b1 || ps2_data_oe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL shift_before_reset got ok=%0d busy=%b data_oe=%b exp 1 1 1", ok, busy, ps2_data_oe);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got clk_oe=%b data_oe=%b busy=%b exp 0 0 0",
               ps2_clk_oe, ps2_data_oe, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send_byte(8'hFF);
    device_frame(11, 1'b1, fr, ok);
    wait_idle(d0);
    tests++;
    if (!ok || fr !== 11'b1_1_11111111_0) begin
      failures++;
      $display("[TB] FAIL ff_frame got=%b exp=%b", fr, 11'b1_1_11111111_0);
    end
    tests++;
    if (done_cnt !== d0 + 1 || ack_at_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ff_done got done=%0d ack=%b exp 1 1", done_cnt - d0, ack_at_done);
    end
  endtask

  task automatic test_valid_while_busy();
    logic [10:0] fr;
    bit ok;
    int d0;
    int i0;
    d0 = done_cnt;
    i0 = inhibit_cnt;
    send_byte(8'h55);
    repeat (5) @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device_frame(11, 1'b1, fr, ok);
    wait_idle(d0);
    tests++;
    if (!ok || fr !== 11'b1_1_01010101_0) begin
      failures++;
      $display("[TB] FAIL busy_frame got=%b exp=%b", fr, 11'b1_1_01010101_0);
    end
    repeat (300) @(negedge clk);
    tests++;
    if (inhibit_cnt !== i0 + 1 || done_cnt !== d0 + 1 || tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_ignore got inhibits=%0d dones=%0d ready=%b exp 1 1 1",
               inhibit_cnt - i0, done_cnt - d0, tx_ready);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests = 0; failures = 0; cyc = 0; done_cnt = 0; err_cnt = 0; err_cyc = 0;
    inhibit_cnt = 0; oe_run = 0; last_oe_run = 0; last_fall_cyc = 0;
    ack_at_done = 1'b0; clk_oe_prev = 1'b0;
    rst_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_send_ed();
    test_send_f4_inhibit();
    test_nak();
    test_timeout();
    test_reset_mid_shift();
    test_valid_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
